// File: rtl/alu_op_arbiter.sv
// Round-robin front end that shares one combinational 4-bit alu between two
// requesters and returns each result on a valid/ready response channel.
module alu_op_arbiter #(
  parameter int WIDTH       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_S,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  input  logic [WIDTH-1:0] alu_Y_add,
  input  logic [WIDTH-1:0] alu_Y_sub,
  input  logic [WIDTH-1:0] alu_Y_and,
  input  logic             alu_carry_add,
  input  logic             alu_carry_sub,
  input  logic             alu_AGB,
  input  logic             alu_AEB,
  input  logic             alu_ALB,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_res,
  output logic             resp_flag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST_EXEC = 4'(EXEC_CYCLES - 1);

  state_t           state;
  logic             prio;
  logic [3:0]       exec_cnt;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] res_sel;
  logic             flag_sel;

  // prio names the requester that wins a tie; it flips to the other side
  // after every grant, which gives alternating service under contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~prio;
        grant1 = prio;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  always_comb begin
    res_sel  = '0;
    flag_sel = 1'b0;
    case (alu_S)
      2'b00: begin
        res_sel  = alu_Y_add;
        flag_sel = alu_carry_add;
      end
      2'b01: begin
        res_sel  = alu_Y_sub;
        flag_sel = alu_carry_sub;
      end
      2'b10:   res_sel = {{(WIDTH-3){1'b0}}, alu_AGB, alu_AEB, alu_ALB};
      default: res_sel = alu_Y_and;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio       <= 1'b0;
      exec_cnt   <= '0;
      alu_S      <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_res   <= '0;
      resp_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_S    <= grant1 ? req1_op : req0_op;
            alu_A    <= grant1 ? req1_a  : req0_a;
            alu_B    <= grant1 ? req1_b  : req0_b;
            resp_id  <= grant1;
            prio     <= grant0;
            exec_cnt <= '0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // The alu inputs have settled for EXEC_CYCLES cycles on the last count.
          if (exec_cnt == LAST_EXEC) begin
            resp_res   <= res_sel;
            resp_flag  <= flag_sel;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            exec_cnt <= exec_cnt + 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            alu_S      <= '0;
            alu_A      <= '0;
            alu_B      <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: two instances (EXEC_CYCLES 1 and 3), each checked
// every cycle against a transaction-level model plus directed literal cases.
module tb_alu_op_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Returns {flag, res} for an op, straight from the arithmetic definitions.
  function automatic logic [4:0] ref_result(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int s;
    logic [4:0] r;
    case (op)
      2'd0: begin
        s = int'(a) + int'(b);
        r = {(s > 15), 4'(s)};
      end
      2'd1: begin
        s = int'(a) - int'(b);
        r = {(a < b), 4'(s)};
      end
      2'd2:    r = {2'b00, (a > b), (a == b), (a < b)};
      default: r = {1'b0, a & b};
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int EC = (g == 0) ? 1 : 3;

    logic       rst_n;
    logic       r0v, r1v, r0r, r1r, resp_ready;
    logic [1:0] r0op, r1op;
    logic [3:0] r0a, r0b, r1a, r1b;
    logic [1:0] alu_S;
    logic [3:0] alu_A, alu_B, y_add, y_sub, y_and, resp_res;
    logic       c_add, c_sub, agb, aeb, alb;
    logic       resp_valid, resp_id, resp_flag, busy;
    bit         fin = 1'b0;

    // Behavioural stand-in for the combinational alu; sub carry is the borrow.
    always_comb begin
      {c_add, y_add} = {1'b0, alu_A} + {1'b0, alu_B};
      y_sub = alu_A - alu_B;
      c_sub = (alu_A < alu_B);
      y_and = alu_A & alu_B;
      agb   = (alu_A > alu_B);
      aeb   = (alu_A == alu_B);
      alb   = (alu_A < alu_B);
    end

    alu_op_arbiter #(.WIDTH(4), .EXEC_CYCLES(EC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
      .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
      .alu_S(alu_S), .alu_A(alu_A), .alu_B(alu_B),
      .alu_Y_add(y_add), .alu_Y_sub(y_sub), .alu_Y_and(y_and),
      .alu_carry_add(c_add), .alu_carry_sub(c_sub),
      .alu_AGB(agb), .alu_AEB(aeb), .alu_ALB(alb),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_res(resp_res), .resp_flag(resp_flag), .busy(busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL ec=%0d %s: got %0h expected %0h at %0t", EC, name, act, exp, $time);
      end
    endtask

    task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL ec=%0d %s: timed out at %0t", EC, name, $time);
    endtask

    // Transaction model: an op is in flight from its accept cycle until its
    // response is taken; it is executing for EC cycles, then responding.
    int         cyc = 0;
    bit         m_armed = 1'b0, m_inflight = 1'b0, m_hist = 1'b0, m_last = 1'b0, m_id = 1'b0;
    int         m_tacc = 0;
    logic [1:0] m_op = '0;
    logic [3:0] m_a = '0, m_b = '0;
    bit         in_resp, tie1, e_r0, e_r1;
    logic [4:0] exp_r;

    always @(negedge clk) begin
      cyc = cyc + 1;
      in_resp = 1'b0;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (m_armed) begin
        in_resp = m_inflight && (cyc > m_tacc + EC);
        tie1 = m_hist && !m_last;
        e_r0 = !m_inflight && r0v && !(r1v && tie1);
        e_r1 = !m_inflight && r1v && !(r0v && !tie1);
        checkOutput("req0_ready", r0r, e_r0);
        checkOutput("req1_ready", r1r, e_r1);
        checkOutput("busy", busy, m_inflight);
        checkOutput("resp_valid", resp_valid, in_resp);
        checkOutput("alu_S", alu_S, m_inflight ? m_op : 2'b00);
        checkOutput("alu_A", alu_A, m_inflight ? m_a : 4'b0000);
        checkOutput("alu_B", alu_B, m_inflight ? m_b : 4'b0000);
        if (in_resp) begin
          exp_r = ref_result(m_op, m_a, m_b);
          checkOutput("resp_id", resp_id, m_id);
          checkOutput("resp_res", resp_res, exp_r[3:0]);
          checkOutput("resp_flag", resp_flag, exp_r[4]);
        end
      end
      if (!rst_n) begin
        m_armed    = 1'b1;
        m_inflight = 1'b0;
        m_hist     = 1'b0;
      end else if (m_armed) begin
        if (!m_inflight && (e_r0 || e_r1)) begin
          m_inflight = 1'b1;
          m_tacc     = cyc;
          m_id       = e_r1;
          m_op       = e_r1 ? r1op : r0op;
          m_a        = e_r1 ? r1a : r0a;
          m_b        = e_r1 ? r1b : r0b;
          m_hist     = 1'b1;
          m_last     = e_r1;
        end else if (in_resp && resp_ready) begin
          m_inflight = 1'b0;
        end
      end
    end

    task automatic applyStimulus(input logic v0, input logic v1, input logic [1:0] op0, input logic [1:0] op1,
                                 input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] a1,
                                 input logic [3:0] b1, input logic rr);
      r0v = v0; r1v = v1; r0op = op0; r1op = op1;
      r0a = a0; r0b = b0; r1a = a1; r1b = b1; resp_ready = rr;
    endtask

    task automatic runOp(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] res, output logic flag, output logic rid, output int lat);
      bit got;
      got = 1'b0;
      res = '0; flag = 1'b0; rid = 1'b0; lat = 0;
      @(posedge clk); #1;
      applyStimulus(!id, id, op, op, a, b, a, b, 1'b1);
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        got = id ? r1r : r0r;
      end
      if (!got) timeoutFail("op_accept");
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
      got = 1'b0;
      for (int n = 1; n <= 40 && !got; n++) begin
        @(negedge clk);
        if (resp_valid) begin
          got = 1'b1; lat = n; res = resp_res; flag = resp_flag; rid = resp_id;
        end
      end
      if (!got) timeoutFail("op_response");
    endtask

    initial begin
      logic [3:0] res;
      logic flag, rid;
      int lat;
      bit got;
      int gr[$];
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      runOp(1'b0, 2'b00, 4'b1110, 4'b0001, res, flag, rid, lat);
      checkOutput("t1_res", res, 4'b1111);
      checkOutput("t1_flag", flag, 1'b0);
      checkOutput("t1_id", rid, 1'b0);
      checkOutput("t1_latency", lat, EC + 1);
      runOp(1'b1, 2'b01, 4'b1010, 4'b0011, res, flag, rid, lat);
      checkOutput("t2_sub_res", res, 4'b0111);
      checkOutput("t2_sub_flag", flag, 1'b0);
      checkOutput("t2_sub_id", rid, 1'b1);
      runOp(1'b1, 2'b10, 4'b1010, 4'b0011, res, flag, rid, lat);
      checkOutput("t2_cmp_res", res, 4'b0100);
      runOp(1'b0, 2'b11, 4'b1010, 4'b0011, res, flag, rid, lat);
      checkOutput("t2_and_res", res, 4'b0010);
      checkOutput("t2_and_flag", flag, 1'b0);

      // Contention straight after reset, then a reset mid-EXEC.
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      applyStimulus(1, 1, 2'b00, 2'b01, 4'd3, 4'd4, 4'd9, 4'd2, 1'b1);
      for (int n = 0; n < 200 && gr.size() < 5; n++) begin
        @(negedge clk);
        if (r0r || r1r) begin
          checkOutput("t3_one_hot", r0r & r1r, 1'b0);
          gr.push_back(int'(r1r));
        end
      end
      if (gr.size() < 5) timeoutFail("t3_grants");
      for (int i = 0; i < gr.size(); i++) checkOutput($sformatf("t3_grant%0d", i), gr[i], i % 2);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t5_busy", busy, 1'b0);
      checkOutput("t5_resp_valid", resp_valid, 1'b0);
      checkOutput("t5_alu_S", alu_S, 2'b00);
      checkOutput("t5_alu_A", alu_A, 4'b0000);
      checkOutput("t5_tie_req0", r0r, 1'b1);
      checkOutput("t5_tie_req1", r1r, 1'b0);
      @(posedge clk); #1 applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
      repeat (EC + 4) @(posedge clk);

      // Consumer stalls for five cycles while both requesters wait.
      #1 applyStimulus(1, 0, 2'b00, 2'b00, 4'd5, 4'd3, 4'd1, 4'd1, 1'b0);
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        got = r0r;
      end
      if (!got) timeoutFail("t4_accept");
      @(posedge clk); #1 applyStimulus(1, 1, 2'b00, 2'b00, 4'd5, 4'd3, 4'd1, 4'd1, 1'b0);
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        got = resp_valid;
      end
      if (!got) timeoutFail("t4_response");
      repeat (5) begin
        @(negedge clk);
        checkOutput("t4_hold_valid", resp_valid, 1'b1);
        checkOutput("t4_hold_res", resp_res, 4'b1000);
        checkOutput("t4_hold_id", resp_id, 1'b0);
        checkOutput("t4_no_ready", r0r | r1r, 1'b0);
        checkOutput("t4_busy", busy, 1'b1);
      end
      @(posedge clk); #1 applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
      @(negedge clk);
      checkOutput("t4_last_valid", resp_valid, 1'b1);
      @(negedge clk);
      checkOutput("t4_released_valid", resp_valid, 1'b0);
      checkOutput("t4_released_busy", busy, 1'b0);

      for (int n = 0; n < 600; n++) begin
        @(posedge clk); #1;
        rst_n = ($urandom_range(0, 49) != 0);
        applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                      2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                      4'($urandom), 4'($urandom), $urandom_range(0, 9) < 7);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
      repeat (EC + 4) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(u[0].fin && u[1].fin); i++) @(posedge clk);
    if (!(u[0].fin && u[1].fin)) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout: stimulus did not complete");
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
